mem_stage: RTL and testbench

- Memory stage directly downstream of the execute stage.
- Consumes the ALU result (address or value) and the rs2 store data.
- Runs a req/ready handshake to data memory, aligns and sign-extends loads, and generates byte enables for stores.
- Registers results toward write-back and stalls upstream while an access is outstanding.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/lsu_align.sv | 57 +++++
 rtl/mem_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings and types for the load/store path.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_LANES = 4;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Data-memory command held stable for the whole outstanding access
  typedef struct packed {
    logic                 we;
    logic [XLEN-1:0]      addr;
    logic [NUM_LANES-1:0] be;
    logic [XLEN-1:0]      wdata;
  } dmem_cmd_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension and alignment check.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [XLEN-1:0]      store_data_i,
  input  logic [XLEN-1:0]      rdata_i,
  output logic [NUM_LANES-1:0] be_o,
  output logic [XLEN-1:0]      wdata_o,
  output logic [XLEN-1:0]      load_data_o,
  output logic                 misaligned_o
);

  logic [15:0] shifted;

  always_comb begin
    be_o         = '0;
    wdata_o      = '0;
    load_data_o  = rdata_i;
    misaligned_o = 1'b0;
    shifted      = 16'(rdata_i >> {addr_lo_i, 3'b000});

    // Size lives in funct3[1:0]; bit 2 only selects zero-extension for loads
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{store_data_i[15:0]}};
      end
      2'b10: begin
        be_o    = 4'hF;
        wdata_o = store_data_i;
      end
      default: ;
    endcase

    case (funct3_i)
      FUNCT3_LB:  load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      FUNCT3_LBU: load_data_o = {24'h0, shifted[7:0]};
      FUNCT3_LH: begin
        load_data_o  = {{16{shifted[15]}}, shifted};
        misaligned_o = addr_lo_i[0];
      end
      FUNCT3_LHU: begin
        load_data_o  = {16'h0, shifted};
        misaligned_o = addr_lo_i[0];
      end
      FUNCT3_LW:  misaligned_o = (addr_lo_i != 2'b00);
      default:    misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: dmem req/ready handshake with timeout, load/store
// alignment and a registered write-back bundle.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] store_data,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ready,
  output logic             stall,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic             wb_reg_write,
  output logic [WIDTH-1:0] wb_data,
  output logic             misaligned,
  output logic             bus_error
);

  localparam int unsigned      CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_cmd_t        cmd_q, cmd_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic [4:0]       rd_q, rd_d;
  logic             regw_q, regw_d;

  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_reg_write_q, wb_reg_write_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             misaligned_q, misaligned_d;
  logic             bus_error_q, bus_error_d;

  logic             in_wait, mem_op, illegal, timeout;
  logic [2:0]       al_funct3;
  logic [1:0]       al_off;
  logic [3:0]       al_be;
  logic [WIDTH-1:0] al_wdata, al_load;
  logic             al_mis;

  // One aligner serves both the accept cycle and the load return in WAIT
  assign in_wait   = (state_q == WAIT);
  assign al_funct3 = in_wait ? funct3_q : funct3;
  assign al_off    = in_wait ? off_q : alu_result[1:0];

  lsu_align u_align (
    .funct3_i     (al_funct3),
    .addr_lo_i    (al_off),
    .store_data_i (store_data),
    .rdata_i      (dmem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load),
    .misaligned_o (al_mis)
  );

  assign mem_op  = mem_read | mem_write;
  assign illegal = al_mis | (mem_read & mem_write)
                 | (mem_write & !(funct3 inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW}));
  assign timeout = ~dmem_ready & (cnt_q == CNT_LAST);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cmd_d          = cmd_q;
    funct3_d       = funct3_q;
    off_d          = off_q;
    rd_d           = rd_q;
    regw_d         = regw_q;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = 1'b0;
    wb_data_d      = wb_data_q;
    misaligned_d   = 1'b0;
    bus_error_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mem_op && !illegal) begin
            state_d     = WAIT;
            cnt_d       = '0;
            cmd_d.we    = mem_write;
            cmd_d.addr  = {alu_result[WIDTH-1:2], 2'b00};
            cmd_d.be    = al_be;
            cmd_d.wdata = al_wdata;
            funct3_d    = funct3;
            off_d       = alu_result[1:0];
            rd_d        = rd;
            regw_d      = reg_write;
          end else begin
            wb_valid_d     = 1'b1;
            wb_rd_d        = rd;
            wb_data_d      = alu_result;
            wb_reg_write_d = mem_op ? 1'b0 : reg_write;
            misaligned_d   = mem_op;
          end
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          state_d        = IDLE;
          cnt_d          = '0;
          wb_valid_d     = 1'b1;
          wb_rd_d        = rd_q;
          wb_reg_write_d = regw_q & ~cmd_q.we;
          wb_data_d      = cmd_q.we ? '0 : al_load;
        end else if (timeout) begin
          state_d     = IDLE;
          cnt_d       = '0;
          wb_valid_d  = 1'b1;
          wb_rd_d     = rd_q;
          wb_data_d   = '0;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cmd_q          <= '0;
      funct3_q       <= '0;
      off_q          <= '0;
      rd_q           <= '0;
      regw_q         <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= '0;
      misaligned_q   <= 1'b0;
      bus_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cmd_q          <= cmd_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
      rd_q           <= rd_d;
      regw_q         <= regw_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_data_q      <= wb_data_d;
      misaligned_q   <= misaligned_d;
      bus_error_q    <= bus_error_d;
    end
  end

  // Command bus is quiet outside WAIT; stall is forced low while in reset
  assign dmem_req   = in_wait;
  assign dmem_we    = in_wait & cmd_q.we;
  assign dmem_addr  = in_wait ? cmd_q.addr : '0;
  assign dmem_wdata = in_wait ? cmd_q.wdata : '0;
  assign dmem_be    = in_wait ? cmd_q.be : '0;
  assign stall      = rst_n & ((~in_wait & in_valid & mem_op & ~illegal)
                             | (in_wait & ~dmem_ready & ~timeout));

  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_data      = wb_data_q;
  assign misaligned   = misaligned_q;
  assign bus_error    = bus_error_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table plus hand sequences, scoreboard on write-back.
module tb_mem_stage;
  import riscv_pkg::*;

  logic        clk, rst_n;
  logic        in_valid, mem_read, mem_write, reg_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result, store_data, dmem_rdata;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we, dmem_ready, stall;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_reg_write, misaligned, bus_error;
  logic [4:0]  wb_rd;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .alu_result(alu_result),
    .store_data(store_data), .rd(rd), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .stall(stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rd_op; logic wr_op; logic [2:0] f3;
    logic [31:0] alu; logic [31:0] sd; logic [4:0] rd; logic regw;
    logic [31:0] rdata; int lat;
    logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_wdata;
    logic [31:0] e_data; logic e_regw; logic e_mis; logic e_chk;
  } vec_t;

  typedef struct {
    logic [4:0] rd; logic [31:0] data; logic regw; logic mis; logic berr; logic chk;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endtask

  // Advance to the next falling edge and score any write-back seen there
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wb_unexpected: got wb_valid=1 want 0");
      end else begin
        e = exp_q.pop_front();
        chk32("wb_rd", 32'(wb_rd), 32'(e.rd));
        if (e.chk) chk32("wb_data", wb_data, e.data);
        chk1("wb_reg_write", wb_reg_write, e.regw);
        chk1("misaligned", misaligned, e.mis);
        chk1("bus_error", bus_error, e.berr);
      end
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [2:0] f3,
                              input logic [31:0] alu, input logic [31:0] sd,
                              input logic [4:0] rdi, input logic regw,
                              input logic [31:0] rdata, input int lat,
                              input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] ed,
                              input logic eregw, input logic emis, input logic echk);
    vec_t v;
    v.rd_op = r; v.wr_op = w; v.f3 = f3; v.alu = alu; v.sd = sd; v.rd = rdi;
    v.regw = regw; v.rdata = rdata; v.lat = lat; v.e_addr = ea; v.e_be = ebe;
    v.e_wdata = ewd; v.e_data = ed; v.e_regw = eregw; v.e_mis = emis; v.e_chk = echk;
    return v;
  endfunction

  task automatic do_op(input vec_t v);
    exp_t e;
    mem_read = v.rd_op; mem_write = v.wr_op; funct3 = v.f3; alu_result = v.alu;
    store_data = v.sd; rd = v.rd; reg_write = v.regw; in_valid = 1'b1; dmem_ready = 1'b0;
    #1;
    e.rd = v.rd; e.data = v.e_data; e.regw = v.e_regw; e.mis = v.e_mis;
    e.berr = 1'b0; e.chk = v.e_chk;
    if (!(v.rd_op | v.wr_op) || v.e_mis) begin
      chk1("stall_no_accept", stall, 1'b0);
      exp_q.push_back(e);
      cyc();
      chk1("no_req", dmem_req, 1'b0);
    end else begin
      chk1("stall_accept", stall, 1'b1);
      chk1("req_in_idle", dmem_req, 1'b0);
      cyc();
      for (int k = 0; k <= v.lat; k++) begin
        dmem_ready = (k == v.lat);
        dmem_rdata = (k == v.lat) ? v.rdata : 32'h5A5A5A5A;
        #1;
        chk1("dmem_req", dmem_req, 1'b1);
        chk32("dmem_addr", dmem_addr, v.e_addr);
        chk1("dmem_we", dmem_we, v.wr_op);
        if (v.wr_op) begin
          chk32("dmem_be", 32'(dmem_be), 32'(v.e_be));
          chk32("dmem_wdata", dmem_wdata, v.e_wdata);
        end
        chk1("stall_wait", stall, (k != v.lat));
        if (k == v.lat) exp_q.push_back(e);
        cyc();
      end
      dmem_ready = 1'b0; in_valid = 1'b0;
      chk1("req_after", dmem_req, 1'b0);
      chk32("be_after", 32'(dmem_be), 32'h0);
    end
    chk32("wb_pending", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int   n;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    alu_result = '0; store_data = '0; rd = '0; reg_write = 1'b0;
    dmem_rdata = '0; dmem_ready = 1'b0;

    tbl.push_back(mk(1'b0,1'b0,3'b000,32'h1234,32'h0,5'd5,1'b1,32'h0,0,32'h0,4'h0,32'h0,32'h1234,1'b1,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,3'b000,32'hDEADBEEF,32'hFFFF,5'd31,1'b0,32'h0,0,32'h0,4'h0,32'h0,32'hDEADBEEF,1'b0,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b1,FUNCT3_SB,32'h103,32'h123456AB,5'd7,1'b1,32'h0,2,32'h100,4'b1000,32'hABABABAB,32'h0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,FUNCT3_LB,32'h202,32'h0,5'd3,1'b1,32'h00F00000,0,32'h200,4'h0,32'h0,32'hFFFFFFF0,1'b1,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,FUNCT3_LBU,32'h202,32'h0,5'd3,1'b1,32'h00F00000,0,32'h200,4'h0,32'h0,32'h000000F0,1'b1,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,FUNCT3_LH,32'h202,32'h0,5'd8,1'b1,32'h80000000,0,32'h200,4'h0,32'h0,32'hFFFF8000,1'b1,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,FUNCT3_LHU,32'h202,32'h0,5'd8,1'b1,32'h80000000,1,32'h200,4'h0,32'h0,32'h00008000,1'b1,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,FUNCT3_LW,32'h208,32'h0,5'd10,1'b1,32'hCAFEF00D,1,32'h208,4'h0,32'h0,32'hCAFEF00D,1'b1,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,FUNCT3_LB,32'h001,32'h0,5'd1,1'b1,32'h00007F00,0,32'h0,4'h0,32'h0,32'h0000007F,1'b1,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b1,FUNCT3_SH,32'h106,32'h0000BEEF,5'd2,1'b0,32'h0,1,32'h104,4'b1100,32'hBEEFBEEF,32'h0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,FUNCT3_SW,32'h10C,32'h11223344,5'd2,1'b1,32'h0,0,32'h10C,4'hF,32'h11223344,32'h0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,FUNCT3_LW,32'h206,32'h0,5'd6,1'b1,32'h0,0,32'h0,4'h0,32'h0,32'h206,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b0,1'b1,FUNCT3_SH,32'h101,32'h0,5'd6,1'b1,32'h0,0,32'h0,4'h0,32'h0,32'h101,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b1,1'b0,3'b011,32'h40,32'h0,5'd11,1'b1,32'h0,0,32'h0,4'h0,32'h0,32'h40,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b1,1'b1,FUNCT3_LW,32'h44,32'h0,5'd12,1'b1,32'h0,0,32'h0,4'h0,32'h0,32'h44,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b0,1'b1,3'b100,32'h48,32'h0,5'd13,1'b1,32'h0,0,32'h0,4'h0,32'h0,32'h48,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b1,1'b0,FUNCT3_LHU,32'h203,32'h0,5'd14,1'b1,32'h0,0,32'h0,4'h0,32'h0,32'h203,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b1,1'b0,FUNCT3_LW,32'h300,32'h0,5'd15,1'b1,32'h0BADF00D,15,32'h300,4'h0,32'h0,32'h0BADF00D,1'b1,1'b0,1'b1));

    #1;
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_dmem_req", dmem_req, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk32("rst_wb_data", wb_data, 32'h0);
    chk1("rst_misaligned", misaligned, 1'b0);
    chk1("rst_bus_error", bus_error, 1'b0);
    chk32("rst_dmem_be", 32'(dmem_be), 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;

    foreach (tbl[i]) do_op(tbl[i]);
    in_valid = 1'b0;
    cyc();

    // Timeout: ready never comes
    mem_read = 1'b1; mem_write = 1'b0; funct3 = FUNCT3_LW; alu_result = 32'h500;
    rd = 5'd9; reg_write = 1'b1; in_valid = 1'b1; dmem_ready = 1'b0;
    #1;
    chk1("stall_timeout_accept", stall, 1'b1);
    e.rd = 5'd9; e.data = 32'h0; e.regw = 1'b0; e.mis = 1'b0; e.berr = 1'b1; e.chk = 1'b0;
    exp_q.push_back(e);
    cyc();
    n = 0;
    while (dmem_req === 1'b1 && n < 40) begin
      n++;
      cyc();
    end
    in_valid = 1'b0;
    chk32("timeout_req_cycles", 32'(n), 32'd16);
    chk32("timeout_wb_pending", 32'(exp_q.size()), 32'h0);
    cyc();

    // Reset asserted mid-access drops the request without a write-back
    mem_read = 1'b1; mem_write = 1'b0; funct3 = FUNCT3_LW; alu_result = 32'h400;
    rd = 5'd4; reg_write = 1'b1; in_valid = 1'b1; dmem_ready = 1'b0;
    cyc(); cyc();
    #1;
    chk1("pre_rst_req", dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rst_mid_req", dmem_req, 1'b0);
    chk1("rst_mid_stall", stall, 1'b0);
    cyc(); cyc();
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    cyc();
    chk1("rst_mid_no_wb", wb_valid, 1'b0);
    do_op(mk(1'b0,1'b0,3'b000,32'h77,32'h0,5'd20,1'b1,32'h0,0,32'h0,4'h0,32'h0,32'h77,1'b1,1'b0,1'b1));
    do_op(mk(1'b1,1'b0,FUNCT3_LH,32'h402,32'h0,5'd21,1'b1,32'h7FFF0000,0,32'h400,4'h0,32'h0,32'h00007FFF,1'b1,1'b0,1'b1));
    cyc();

    chk32("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
